// File: rtl/cpu_control_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_control_unit_if : control-unit <-> EU / memory strobe bundle         |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cpu_control_unit_if;
   logic [15:0] ir;
   logic        C;
   logic        N;
   logic        Z;
   logic        mem_rdy;
   logic        w_en;
   logic        s_sel;
   logic        pc_ld;
   logic        pc_inc;
   logic        ir_ld;
   logic        adr_sel;
   logic        mem_rd;
   logic        mem_wr;
   logic        instr_done;
   logic        halted;
   logic        fault;

   modport master (
      input  ir, C, N, Z, mem_rdy,
      output w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel,
             mem_rd, mem_wr, instr_done, halted, fault
   );

   modport slave (
      output ir, C, N, Z, mem_rdy,
      input  w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel,
             mem_rd, mem_wr, instr_done, halted, fault
   );
endinterface
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_control_unit : multi-cycle fetch/decode/execute sequencer for the EU |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cpu_control_unit #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic              clk,
   input  logic              reset,
   cpu_control_unit_if.master bus
);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EX_ALU = 4'd3,
      S_LD     = 4'd4,
      S_ST     = 4'd5,
      S_JMP    = 4'd6,
      S_BR     = 4'd7,
      S_HALT   = 4'd8,
      S_FAULT  = 4'd9
   } state_t;

   localparam logic [2:0] c_CLS_ALU   = 3'b000;
   localparam logic [2:0] c_CLS_LOAD  = 3'b001;
   localparam logic [2:0] c_CLS_STORE = 3'b010;
   localparam logic [2:0] c_CLS_JMP   = 3'b011;
   localparam logic [2:0] c_CLS_BR    = 3'b100;
   localparam logic [2:0] c_CLS_HALT  = 3'b111;

   state_t          r_state;
   state_t          w_next;
   logic [TO_W-1:0] r_cnt;
   logic [2:0]      r_flags;
   logic            r_w_en_alu;
   logic            r_pc_ld;
   logic            r_adr_sel;
   logic            r_mem_rd;
   logic            r_mem_wr;
   logic            r_done_fixed;
   logic            r_halted;
   logic            r_fault;
   logic            w_mem_state;
   logic            w_wait;
   logic            w_timeout;
   logic            w_mem_done;
   logic            w_unused_ir;

   // Flag copy is ordered {C,N,Z}.
   function automatic logic br_cond(input logic [2:0] cond, input logic [2:0] f);
      case (cond)
         3'b000:  return 1'b1;
         3'b001:  return f[0];
         3'b010:  return ~f[0];
         3'b011:  return f[2];
         3'b100:  return ~f[2];
         3'b101:  return f[1];
         3'b110:  return ~f[1];
         default: return 1'b0;
      endcase
   endfunction

   assign w_mem_state = (r_state == S_FETCH) || (r_state == S_LD) || (r_state == S_ST);
   assign w_wait      = w_mem_state && !bus.mem_rdy;
   assign w_mem_done  = ((r_state == S_LD) || (r_state == S_ST)) && bus.mem_rdy;
   assign w_unused_ir = ^{bus.ir[15:12], bus.ir[5:0]};

   // The limit fires on the wait cycle that would take the counter to TIMEOUT.
   generate
      if (TIMEOUT != 0) begin : g_timeout_on
         assign w_timeout = w_wait && (r_cnt == TO_W'(TIMEOUT - 1));
      end else begin : g_timeout_off
         assign w_timeout = 1'b0;
      end
   endgenerate

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST:    w_next = S_FETCH;
         S_FETCH: begin
            if (bus.mem_rdy)    w_next = S_DECODE;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_DECODE: begin
            case (bus.ir[11:9])
               c_CLS_ALU:   w_next = S_EX_ALU;
               c_CLS_LOAD:  w_next = S_LD;
               c_CLS_STORE: w_next = S_ST;
               c_CLS_JMP:   w_next = S_JMP;
               c_CLS_BR:    w_next = S_BR;
               c_CLS_HALT:  w_next = S_HALT;
               default:     w_next = S_FAULT;
            endcase
         end
         S_EX_ALU, S_JMP, S_BR: w_next = S_FETCH;
         S_LD, S_ST: begin
            if (bus.mem_rdy)    w_next = S_FETCH;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_HALT:   w_next = S_HALT;
         S_FAULT:  w_next = S_FAULT;
         default:  w_next = S_FAULT;
      endcase
   end

   // State-only outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_RST;
         r_cnt        <= '0;
         r_flags      <= 3'b000;
         r_w_en_alu   <= 1'b0;
         r_pc_ld      <= 1'b0;
         r_adr_sel    <= 1'b0;
         r_mem_rd     <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_done_fixed <= 1'b0;
         r_halted     <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_cnt        <= (w_wait && (w_next == r_state)) ? r_cnt + TO_W'(1) : '0;
         if (r_state == S_EX_ALU) begin
            r_flags <= {bus.C, bus.N, bus.Z};
         end
         r_w_en_alu   <= (w_next == S_EX_ALU);
         r_pc_ld      <= (w_next == S_JMP) ||
                         ((w_next == S_BR) && br_cond(bus.ir[8:6], r_flags));
         r_adr_sel    <= (w_next == S_LD) || (w_next == S_ST);
         r_mem_rd     <= (w_next == S_FETCH) || (w_next == S_LD);
         r_mem_wr     <= (w_next == S_ST);
         r_done_fixed <= (w_next == S_EX_ALU) || (w_next == S_JMP) || (w_next == S_BR);
         r_halted     <= (w_next == S_HALT);
         r_fault      <= (w_next == S_FAULT);
      end
   end

   assign bus.w_en       = r_w_en_alu || ((r_state == S_LD) && bus.mem_rdy);
   assign bus.s_sel      = (r_state == S_LD) && bus.mem_rdy;
   assign bus.pc_ld      = r_pc_ld;
   assign bus.pc_inc     = (r_state == S_FETCH) && bus.mem_rdy;
   assign bus.ir_ld      = (r_state == S_FETCH) && bus.mem_rdy;
   assign bus.adr_sel    = r_adr_sel;
   assign bus.mem_rd     = r_mem_rd;
   assign bus.mem_wr     = r_mem_wr;
   assign bus.instr_done = r_done_fixed || w_mem_done;
   assign bus.halted     = r_halted;
   assign bus.fault      = r_fault;

endmodule
`default_nettype wire
